// File: rtl/sdram_burst_arbiter_pkg.sv
// sdram_burst_arbiter_pkg
//   Shared types and default widths for the SDRAM burst arbiter.
//   - grant_e : encoding of the current grant as seen on grant_id
//   - state_e : arbiter state machine encoding
//   - PICK_*  : bit positions of the one-hot winner from the selector
package sdram_burst_arbiter_pkg;

    localparam int DEF_ADDR_BITS  = 24;
    localparam int DEF_DATA_BITS  = 16;
    localparam int DEF_LEN_BITS   = 10;
    localparam int DEF_MAX_M0_RUN = 4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_M0   = 2'd1,
        GRANT_M1   = 2'd2
    } grant_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2
    } state_e;

    localparam int PICK_M0_RD = 0;
    localparam int PICK_M1_WR = 1;
    localparam int PICK_M1_RD = 2;
    localparam int PICK_M0_WR = 3;

endpackage

// File: rtl/sdram_burst_arbiter_arb_pick.sv
// sdram_burst_arbiter_arb_pick
//   Combinational winner selection for one burst grant.
//   Ports:
//     m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req : pending master requests
//     m0_run_sat  : M0 has used up its consecutive-grant allowance
//     rr_rd_first : when both M1 channels want service, the read wins
//     pick        : one-hot winner, bit positions PICK_* from the package
module sdram_burst_arbiter_arb_pick
    import sdram_burst_arbiter_pkg::*;
(
    input  logic       m0_rd_req,
    input  logic       m0_wr_req,
    input  logic       m1_rd_req,
    input  logic       m1_wr_req,
    input  logic       m0_run_sat,
    input  logic       rr_rd_first,
    output logic [3:0] pick
);

    logic m1_pending;

    assign m1_pending = m1_rd_req | m1_wr_req;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else chain can leave it unassigned (no latch).
    always_comb begin
        pick = '0;
        // Display reads first, unless M0 has hogged the port while M1 waits.
        if (m0_rd_req && !(m0_run_sat && m1_pending)) begin
            pick[PICK_M0_RD] = 1'b1;
        end else if (m1_wr_req && m1_rd_req) begin
            if (rr_rd_first) pick[PICK_M1_RD] = 1'b1;
            else             pick[PICK_M1_WR] = 1'b1;
        end else if (m1_wr_req) begin
            pick[PICK_M1_WR] = 1'b1;
        end else if (m1_rd_req) begin
            pick[PICK_M1_RD] = 1'b1;
        end else if (m0_wr_req) begin
            pick[PICK_M0_WR] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
//   Shares one sdram_core burst port between two masters (M0 display read
//   path, M1 drawing path). One whole burst is granted at a time; M0 reads
//   have priority, bounded by MAX_M0_RUN consecutive M0 grants while M1 waits.
//   Ports:
//     clk, rst_n                 : memory clock, async active-low reset
//     mN_wr_burst_*  (N=0,1)     : master write request / data, demuxed
//                                  data_req and finish back to the master
//     mN_rd_burst_*  (N=0,1)     : master read request, read data (broadcast),
//                                  demuxed data_valid and finish
//     wr_burst_*, rd_burst_*     : core burst channels
//     grant_id                   : current grant {0 none, 1 M0, 2 M1}
module sdram_burst_arbiter
    import sdram_burst_arbiter_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int LEN_BITS   = DEF_LEN_BITS,
    parameter int MAX_M0_RUN = DEF_MAX_M0_RUN
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_wr_burst_req,
    input  logic [LEN_BITS-1:0]  m0_wr_burst_len,
    input  logic [ADDR_BITS-1:0] m0_wr_burst_addr,
    input  logic [DATA_BITS-1:0] m0_wr_burst_data,
    output logic                 m0_wr_burst_data_req,
    output logic                 m0_wr_burst_finish,
    input  logic                 m0_rd_burst_req,
    input  logic [LEN_BITS-1:0]  m0_rd_burst_len,
    input  logic [ADDR_BITS-1:0] m0_rd_burst_addr,
    output logic [DATA_BITS-1:0] m0_rd_burst_data,
    output logic                 m0_rd_burst_data_valid,
    output logic                 m0_rd_burst_finish,

    input  logic                 m1_wr_burst_req,
    input  logic [LEN_BITS-1:0]  m1_wr_burst_len,
    input  logic [ADDR_BITS-1:0] m1_wr_burst_addr,
    input  logic [DATA_BITS-1:0] m1_wr_burst_data,
    output logic                 m1_wr_burst_data_req,
    output logic                 m1_wr_burst_finish,
    input  logic                 m1_rd_burst_req,
    input  logic [LEN_BITS-1:0]  m1_rd_burst_len,
    input  logic [ADDR_BITS-1:0] m1_rd_burst_addr,
    output logic [DATA_BITS-1:0] m1_rd_burst_data,
    output logic                 m1_rd_burst_data_valid,
    output logic                 m1_rd_burst_finish,

    output logic                 wr_burst_req,
    output logic [LEN_BITS-1:0]  wr_burst_len,
    output logic [ADDR_BITS-1:0] wr_burst_addr,
    output logic [DATA_BITS-1:0] wr_burst_data,
    input  logic                 wr_burst_data_req,
    input  logic                 wr_burst_finish,
    output logic                 rd_burst_req,
    output logic [LEN_BITS-1:0]  rd_burst_len,
    output logic [ADDR_BITS-1:0] rd_burst_addr,
    input  logic [DATA_BITS-1:0] rd_burst_data,
    input  logic                 rd_burst_data_valid,
    input  logic                 rd_burst_finish,

    output logic [1:0]           grant_id
);

    localparam int RUN_BITS = $clog2(MAX_M0_RUN + 1);

    state_e               state, state_nxt;
    grant_e               grant_q;
    logic [LEN_BITS-1:0]  len_q, len_sel;
    logic [ADDR_BITS-1:0] addr_q, addr_sel;
    logic [RUN_BITS-1:0]  m0_run;
    logic                 rr_rd_first;
    logic [3:0]           pick;
    logic                 m0_run_sat, m1_pending, start, pick_m0, pick_rd;
    logic                 wr_busy, rd_busy, to_m0, to_m1;

    assign m0_run_sat = (m0_run == RUN_BITS'(MAX_M0_RUN));
    assign m1_pending = m1_wr_burst_req | m1_rd_burst_req;

    sdram_burst_arbiter_arb_pick u_pick (
        .m0_rd_req   (m0_rd_burst_req),
        .m0_wr_req   (m0_wr_burst_req),
        .m1_rd_req   (m1_rd_burst_req),
        .m1_wr_req   (m1_wr_burst_req),
        .m0_run_sat  (m0_run_sat),
        .rr_rd_first (rr_rd_first),
        .pick        (pick)
    );

    assign pick_m0 = pick[PICK_M0_RD] | pick[PICK_M0_WR];
    assign pick_rd = pick[PICK_M0_RD] | pick[PICK_M1_RD];
    assign start   = (state == ST_IDLE) && (pick != '0);

    // Parameters of the winning request, captured on entry to BUSY.
    always_comb begin
        len_sel  = '0;
        addr_sel = '0;
        if (pick[PICK_M0_RD]) begin
            len_sel  = m0_rd_burst_len;
            addr_sel = m0_rd_burst_addr;
        end else if (pick[PICK_M1_WR]) begin
            len_sel  = m1_wr_burst_len;
            addr_sel = m1_wr_burst_addr;
        end else if (pick[PICK_M1_RD]) begin
            len_sel  = m1_rd_burst_len;
            addr_sel = m1_rd_burst_addr;
        end else if (pick[PICK_M0_WR]) begin
            len_sel  = m0_wr_burst_len;
            addr_sel = m0_wr_burst_addr;
        end
    end

    // NOTE: state elements use non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Only the finish of the granted direction ends a burst; a stray finish
    // on the other channel is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = pick_rd ? ST_RD_BUSY : ST_WR_BUSY;
            ST_WR_BUSY: if (wr_burst_finish) state_nxt = ST_IDLE;
            ST_RD_BUSY: if (rd_burst_finish) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= GRANT_NONE;
            len_q   <= '0;
            addr_q  <= '0;
        end else if (start) begin
            grant_q <= pick_m0 ? GRANT_M0 : GRANT_M1;
            len_q   <= len_sel;
            addr_q  <= addr_sel;
        end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
            grant_q <= GRANT_NONE;
        end
    end

    // m0_run counts M0 grants made while M1 was waiting; any M1 grant, or an
    // M0 grant with M1 idle, restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_run      <= '0;
            rr_rd_first <= 1'b0;
        end else if (start) begin
            if (pick_m0) begin
                if (!m1_pending)      m0_run <= '0;
                else if (!m0_run_sat) m0_run <= m0_run + RUN_BITS'(1);
            end else begin
                m0_run      <= '0;
                rr_rd_first <= pick[PICK_M1_WR];
            end
        end
    end

    assign wr_busy = (state == ST_WR_BUSY);
    assign rd_busy = (state == ST_RD_BUSY);
    assign to_m0   = (grant_q == GRANT_M0);
    assign to_m1   = (grant_q == GRANT_M1);

    assign wr_burst_req  = wr_busy;
    assign wr_burst_len  = wr_busy ? len_q  : '0;
    assign wr_burst_addr = wr_busy ? addr_q : '0;
    assign wr_burst_data = (wr_busy && to_m0) ? m0_wr_burst_data :
                           (wr_busy && to_m1) ? m1_wr_burst_data : '0;
    assign rd_burst_req  = rd_busy;
    assign rd_burst_len  = rd_busy ? len_q  : '0;
    assign rd_burst_addr = rd_busy ? addr_q : '0;

    // Strobes are demuxed combinationally so write data meets data_req in
    // the same cycle.
    assign m0_wr_burst_data_req   = wr_busy & to_m0 & wr_burst_data_req;
    assign m0_wr_burst_finish     = wr_busy & to_m0 & wr_burst_finish;
    assign m1_wr_burst_data_req   = wr_busy & to_m1 & wr_burst_data_req;
    assign m1_wr_burst_finish     = wr_busy & to_m1 & wr_burst_finish;
    assign m0_rd_burst_data_valid = rd_busy & to_m0 & rd_burst_data_valid;
    assign m0_rd_burst_finish     = rd_busy & to_m0 & rd_burst_finish;
    assign m1_rd_burst_data_valid = rd_busy & to_m1 & rd_burst_data_valid;
    assign m1_rd_burst_finish     = rd_busy & to_m1 & rd_burst_finish;

    assign m0_rd_burst_data = rd_busy ? rd_burst_data : '0;
    assign m1_rd_burst_data = rd_busy ? rd_burst_data : '0;

    assign grant_id = grant_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter
//   Directed bench for sdram_burst_arbiter. A transaction-level model tracks
//   which burst should own the core port; a negedge process compares every
//   DUT output against it each cycle, and each scenario pins grant order and
//   beat counts with hand-computed literals.
module tb_sdram_burst_arbiter;

    localparam int AB   = 24;
    localparam int DB   = 16;
    localparam int LB   = 10;
    localparam int MAXR = 4;

    // channel codes: master*2 + (read ? 1 : 0)
    localparam int C_M0W = 0;
    localparam int C_M0R = 1;
    localparam int C_M1W = 2;
    localparam int C_M1R = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m0_wr_burst_req = 0, m0_rd_burst_req = 0;
    logic          m1_wr_burst_req = 0, m1_rd_burst_req = 0;
    logic [LB-1:0] m0_wr_burst_len = 0, m0_rd_burst_len = 0;
    logic [LB-1:0] m1_wr_burst_len = 0, m1_rd_burst_len = 0;
    logic [AB-1:0] m0_wr_burst_addr = 0, m0_rd_burst_addr = 0;
    logic [AB-1:0] m1_wr_burst_addr = 0, m1_rd_burst_addr = 0;
    logic [DB-1:0] m0_wr_burst_data = 0, m1_wr_burst_data = 0;
    logic          m0_wr_burst_data_req, m0_wr_burst_finish;
    logic          m1_wr_burst_data_req, m1_wr_burst_finish;
    logic [DB-1:0] m0_rd_burst_data, m1_rd_burst_data;
    logic          m0_rd_burst_data_valid, m0_rd_burst_finish;
    logic          m1_rd_burst_data_valid, m1_rd_burst_finish;

    logic          wr_burst_req, rd_burst_req;
    logic [LB-1:0] wr_burst_len, rd_burst_len;
    logic [AB-1:0] wr_burst_addr, rd_burst_addr;
    logic [DB-1:0] wr_burst_data;
    logic          c_wr_dreq = 0, c_wr_fin = 0;
    logic [DB-1:0] c_rd_data = 0;
    logic          c_rd_valid = 0, c_rd_fin = 0;
    logic [1:0]    grant_id;

    sdram_burst_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .LEN_BITS(LB), .MAX_M0_RUN(MAXR)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .m0_wr_burst_req        (m0_wr_burst_req),
        .m0_wr_burst_len        (m0_wr_burst_len),
        .m0_wr_burst_addr       (m0_wr_burst_addr),
        .m0_wr_burst_data       (m0_wr_burst_data),
        .m0_wr_burst_data_req   (m0_wr_burst_data_req),
        .m0_wr_burst_finish     (m0_wr_burst_finish),
        .m0_rd_burst_req        (m0_rd_burst_req),
        .m0_rd_burst_len        (m0_rd_burst_len),
        .m0_rd_burst_addr       (m0_rd_burst_addr),
        .m0_rd_burst_data       (m0_rd_burst_data),
        .m0_rd_burst_data_valid (m0_rd_burst_data_valid),
        .m0_rd_burst_finish     (m0_rd_burst_finish),
        .m1_wr_burst_req        (m1_wr_burst_req),
        .m1_wr_burst_len        (m1_wr_burst_len),
        .m1_wr_burst_addr       (m1_wr_burst_addr),
        .m1_wr_burst_data       (m1_wr_burst_data),
        .m1_wr_burst_data_req   (m1_wr_burst_data_req),
        .m1_wr_burst_finish     (m1_wr_burst_finish),
        .m1_rd_burst_req        (m1_rd_burst_req),
        .m1_rd_burst_len        (m1_rd_burst_len),
        .m1_rd_burst_addr       (m1_rd_burst_addr),
        .m1_rd_burst_data       (m1_rd_burst_data),
        .m1_rd_burst_data_valid (m1_rd_burst_data_valid),
        .m1_rd_burst_finish     (m1_rd_burst_finish),
        .wr_burst_req           (wr_burst_req),
        .wr_burst_len           (wr_burst_len),
        .wr_burst_addr          (wr_burst_addr),
        .wr_burst_data          (wr_burst_data),
        .wr_burst_data_req      (c_wr_dreq),
        .wr_burst_finish        (c_wr_fin),
        .rd_burst_req           (rd_burst_req),
        .rd_burst_len           (rd_burst_len),
        .rd_burst_addr          (rd_burst_addr),
        .rd_burst_data          (c_rd_data),
        .rd_burst_data_valid    (c_rd_valid),
        .rd_burst_finish        (c_rd_fin),
        .grant_id               (grant_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- master stimulus ----------------
    int            rem[4];
    logic [LB-1:0] ch_len[4];
    logic [AB-1:0] ch_addr[4];
    int            step_cnt = 0;

    task automatic apply_reqs();
        m0_wr_burst_req  = rem[C_M0W] > 0;
        m0_rd_burst_req  = rem[C_M0R] > 0;
        m1_wr_burst_req  = rem[C_M1W] > 0;
        m1_rd_burst_req  = rem[C_M1R] > 0;
        m0_wr_burst_len  = ch_len[C_M0W];  m0_wr_burst_addr = ch_addr[C_M0W];
        m0_rd_burst_len  = ch_len[C_M0R];  m0_rd_burst_addr = ch_addr[C_M0R];
        m1_wr_burst_len  = ch_len[C_M1W];  m1_wr_burst_addr = ch_addr[C_M1W];
        m1_rd_burst_len  = ch_len[C_M1R];  m1_rd_burst_addr = ch_addr[C_M1R];
    endtask

    task automatic set_ch(input int c, input int len, input int addr, input int n);
        ch_len[c]  = LB'(len);
        ch_addr[c] = AB'(addr);
        rem[c]     = n;
        apply_reqs();
    endtask

    // ---------------- reference model ----------------
    bit            md_busy = 0, md_rd = 0, md_rr_rd = 0;
    int            md_master = 0, md_run = 0;
    logic [LB-1:0] md_len = 0;
    logic [AB-1:0] md_addr = 0;
    int            model_log[$];

    task automatic model_reset();
        md_busy = 0; md_rd = 0; md_rr_rd = 0; md_master = 0; md_run = 0;
        md_len = 0; md_addr = 0;
    endtask

    // One clock edge of the arbitration rules, from the inputs at the edge.
    task automatic model_edge();
        bit m1p;
        int choice;
        if (md_busy) begin
            if ((!md_rd && c_wr_fin) || (md_rd && c_rd_fin)) md_busy = 0;
        end else begin
            m1p    = m1_wr_burst_req || m1_rd_burst_req;
            choice = -1;
            if (m0_rd_burst_req && !(md_run == MAXR && m1p)) choice = C_M0R;
            else if (m1_wr_burst_req && m1_rd_burst_req)     choice = md_rr_rd ? C_M1R : C_M1W;
            else if (m1_wr_burst_req)                        choice = C_M1W;
            else if (m1_rd_burst_req)                        choice = C_M1R;
            else if (m0_wr_burst_req)                        choice = C_M0W;
            if (choice >= 0) begin
                md_busy   = 1;
                md_master = choice / 2;
                md_rd     = (choice % 2) == 1;
                md_len    = ch_len[choice];
                md_addr   = ch_addr[choice];
                model_log.push_back(choice);
                if (md_master == 0) begin
                    if (!m1p)             md_run = 0;
                    else if (md_run < MAXR) md_run = md_run + 1;
                end else begin
                    md_run   = 0;
                    md_rr_rd = !md_rd;
                end
            end
        end
    endtask

    // ---------------- core responder ----------------
    bit   wact = 0, ract = 0, inject_rd_fin = 0;
    int   wcnt = 0, rcnt = 0;
    logic [DB-1:0] rd_pat = 16'h1000;

    task automatic core_update();
        if (!rst_n) begin
            c_wr_dreq = 0; c_wr_fin = 0; c_rd_valid = 0; c_rd_fin = 0; c_rd_data = 0;
            wact = 0; ract = 0;
            return;
        end
        c_wr_dreq  = 0; c_wr_fin = 0; c_rd_valid = 0;
        c_rd_fin   = inject_rd_fin;
        inject_rd_fin = 0;
        if (!wact && wr_burst_req) begin wact = 1; wcnt = int'(wr_burst_len); end
        if (wact) begin
            if (wcnt > 0) begin c_wr_dreq = 1; wcnt--; end
            else begin c_wr_fin = 1; wact = 0; end
        end
        if (!ract && rd_burst_req) begin ract = 1; rcnt = int'(rd_burst_len); end
        if (ract) begin
            if (rcnt > 0) begin c_rd_valid = 1; c_rd_data = rd_pat; rd_pat = rd_pat + 16'h3; rcnt--; end
            else begin c_rd_fin = 1; ract = 0; end
        end
    endtask

    // One clock: sample master finishes, advance model at the edge, then
    // drive the next cycle's inputs.
    task automatic step();
        bit f0w, f0r, f1w, f1r;
        @(negedge clk);
        f0w = m0_wr_burst_finish; f0r = m0_rd_burst_finish;
        f1w = m1_wr_burst_finish; f1r = m1_rd_burst_finish;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        if (f0w && rem[C_M0W] > 0) rem[C_M0W]--;
        if (f0r && rem[C_M0R] > 0) rem[C_M0R]--;
        if (f1w && rem[C_M1W] > 0) rem[C_M1W]--;
        if (f1r && rem[C_M1R] > 0) rem[C_M1R]--;
        apply_reqs();
        step_cnt++;
        m0_wr_burst_data = DB'(step_cnt * 7 + 1);
        m1_wr_burst_data = DB'(step_cnt * 13 + 5);
        core_update();
    endtask

    // ---------------- per-cycle compare ----------------
    int cyc = 0, last_rd_fin_cyc = 0;
    int cnt_m0_wdreq = 0, cnt_m1_wdreq = 0, cnt_m0_val = 0, cnt_m1_val = 0;
    int cnt_m0_wfin = 0, cnt_m1_wfin = 0, cnt_m0_rfin = 0, cnt_m1_rfin = 0;
    int dut_log[$], dut_log_cyc[$];
    logic [1:0] prev_gid = 0;

    always @(negedge clk) begin : compare
        logic e_wr, e_rd, e0, e1;
        logic [7:0] e_strb, a_strb;
        cyc++;
        e_wr = md_busy && !md_rd;
        e_rd = md_busy && md_rd;
        e0   = md_master == 0;
        e1   = md_master == 1;
        check("grant_id", grant_id, md_busy ? 64'(md_master + 1) : 64'd0);
        check("wr_burst_req", wr_burst_req, e_wr);
        check("rd_burst_req", rd_burst_req, e_rd);
        check("wr_len_addr", {wr_burst_len, wr_burst_addr}, e_wr ? {md_len, md_addr} : '0);
        check("rd_len_addr", {rd_burst_len, rd_burst_addr}, e_rd ? {md_len, md_addr} : '0);
        check("wr_burst_data", wr_burst_data,
              !e_wr ? '0 : (e0 ? m0_wr_burst_data : m1_wr_burst_data));
        check("rd_data_bcast", {m0_rd_burst_data, m1_rd_burst_data},
              e_rd ? {c_rd_data, c_rd_data} : '0);
        e_strb = {e_wr & e0 & c_wr_dreq, e_wr & e0 & c_wr_fin,
                  e_rd & e0 & c_rd_valid, e_rd & e0 & c_rd_fin,
                  e_wr & e1 & c_wr_dreq, e_wr & e1 & c_wr_fin,
                  e_rd & e1 & c_rd_valid, e_rd & e1 & c_rd_fin};
        a_strb = {m0_wr_burst_data_req, m0_wr_burst_finish,
                  m0_rd_burst_data_valid, m0_rd_burst_finish,
                  m1_wr_burst_data_req, m1_wr_burst_finish,
                  m1_rd_burst_data_valid, m1_rd_burst_finish};
        check("strobe_route", a_strb, e_strb);

        if (m0_wr_burst_data_req)   cnt_m0_wdreq++;
        if (m1_wr_burst_data_req)   cnt_m1_wdreq++;
        if (m0_rd_burst_data_valid) cnt_m0_val++;
        if (m1_rd_burst_data_valid) cnt_m1_val++;
        if (m0_wr_burst_finish)     cnt_m0_wfin++;
        if (m1_wr_burst_finish)     cnt_m1_wfin++;
        if (m0_rd_burst_finish)     cnt_m0_rfin++;
        if (m1_rd_burst_finish)     cnt_m1_rfin++;
        if (c_rd_fin)               last_rd_fin_cyc = cyc;
        if (grant_id != 2'd0 && prev_gid == 2'd0) begin
            dut_log.push_back((grant_id == 2'd2 ? 2 : 0) + (rd_burst_req ? 1 : 0));
            dut_log_cyc.push_back(cyc);
        end
        prev_gid = grant_id;
    end

    // ---------------- helpers ----------------
    task automatic clear_stats();
        cnt_m0_wdreq = 0; cnt_m1_wdreq = 0; cnt_m0_val = 0; cnt_m1_val = 0;
        cnt_m0_wfin = 0; cnt_m1_wfin = 0; cnt_m0_rfin = 0; cnt_m1_rfin = 0;
        dut_log.delete(); dut_log_cyc.delete(); model_log.delete();
    endtask

    task automatic reset_dut();
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 4; i++) rem[i] = 0;
        apply_reqs();
        core_update();
        step();
        step();
        rst_n = 1;
        clear_stats();
    endtask

    task automatic run_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3] > 0 || md_busy || wact || ract) && n < budget) begin
            step();
            n++;
        end
        check({name, " done within budget"}, n < budget, 1);
        step();
        step();
    endtask

    task automatic wait_wr_req(input string name);
        int n;
        n = 0;
        while (!wr_burst_req && n < 10) begin step(); n++; end
        check({name, " write granted"}, wr_burst_req, 1);
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, " dut grant count"}, dut_log.size(), exp.size());
        check({name, " model grant count"}, model_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < dut_log.size())   check({name, " dut grant"}, dut_log[i], exp[i]);
            if (i < model_log.size()) check({name, " model grant"}, model_log[i], exp[i]);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int exp_q[$];
        for (int i = 0; i < 4; i++) begin rem[i] = 0; ch_len[i] = 0; ch_addr[i] = 0; end

        // reset values
        #12;
        check("reset grant_id", grant_id, 0);
        check("reset core reqs", {wr_burst_req, rd_burst_req}, 0);
        check("reset wr_burst_data", wr_burst_data, 0);

        // single M0 read, len 128
        reset_dut();
        set_ch(C_M0R, 128, 0, 1);
        step();
        #2;
        check("t1 rd_req after 1 cycle", rd_burst_req, 1);
        check("t1 rd_len", rd_burst_len, 128);
        check("t1 grant_id", grant_id, 1);
        run_quiet("t1", 300);
        check("t1 m0 valid beats", cnt_m0_val, 128);
        check("t1 m1 valid beats", cnt_m1_val, 0);
        check("t1 m0 rd finish", cnt_m0_rfin, 1);
        check("t1 idle grant_id", grant_id, 0);
        exp_q = '{1};
        check_log("t1", exp_q);

        // read priority over write, fixed bubble
        reset_dut();
        set_ch(C_M0R, 8, 'h100, 1);
        set_ch(C_M1W, 6, 'h200, 1);
        run_quiet("t2", 100);
        exp_q = '{1, 2};
        check_log("t2", exp_q);
        if (dut_log_cyc.size() == 2)
            check("t2 m1 grant 2 cycles after rd_finish", dut_log_cyc[1] - last_rd_fin_cyc, 2);
        else
            check("t2 grant cycles recorded", dut_log_cyc.size(), 2);
        check("t2 m1 write beats", cnt_m1_wdreq, 6);

        // starvation guard
        reset_dut();
        set_ch(C_M0R, 4, 'h40, 5);
        set_ch(C_M1W, 4, 'h80, 1);
        run_quiet("t3", 200);
        exp_q = '{1, 1, 1, 1, 2, 1};
        check_log("t3", exp_q);

        // M1 round-robin
        reset_dut();
        set_ch(C_M1W, 5, 'h1000, 2);
        set_ch(C_M1R, 5, 'h2000, 2);
        run_quiet("t4", 200);
        exp_q = '{2, 3, 2, 3};
        check_log("t4", exp_q);
        check("t4 m1 write beats", cnt_m1_wdreq, 10);
        check("t4 m1 read beats", cnt_m1_val, 10);
        check("t4 m0 strobes", cnt_m0_wdreq + cnt_m0_val, 0);

        // reset in the middle of a 100-word write
        reset_dut();
        set_ch(C_M1W, 100, 'h3000, 1);
        wait_wr_req("t5");
        for (int i = 0; i < 30; i++) step();
        set_ch(C_M0R, 16, 'h77, 1);
        step();
        #2;
        rst_n = 0;
        model_reset();
        core_update();
        rem[C_M1W] = 0;
        apply_reqs();
        #1;
        check("t5 async wr_req", wr_burst_req, 0);
        check("t5 async grant_id", grant_id, 0);
        check("t5 async wr len/addr/data", {wr_burst_len, wr_burst_addr, wr_burst_data}, 0);
        check("t5 async m1 data_req", m1_wr_burst_data_req, 0);
        step();
        step();
        rst_n = 1;
        step();
        #2;
        check("t5 m0_rd granted after release", {grant_id, rd_burst_req}, {2'd1, 1'b1});
        check("t5 rd addr", rd_burst_addr, 'h77);
        run_quiet("t5", 100);
        check("t5 m0 rd finish", cnt_m0_rfin, 1);
        check("t5 m1 wr finish", cnt_m1_wfin, 0);

        // stray read finish during a write burst
        reset_dut();
        set_ch(C_M0W, 20, 'h500, 1);
        wait_wr_req("t6");
        for (int i = 0; i < 5; i++) step();
        inject_rd_fin = 1;
        step();
        #2;
        check("t6 stray finish not routed", {m0_rd_burst_finish, m1_rd_burst_finish, m0_wr_burst_finish}, 0);
        step();
        #2;
        check("t6 still busy", {grant_id, wr_burst_req}, {2'd1, 1'b1});
        run_quiet("t6", 100);
        check("t6 m0 write beats", cnt_m0_wdreq, 20);
        check("t6 m0 wr finish", cnt_m0_wfin, 1);
        check("t6 rd finishes", cnt_m0_rfin + cnt_m1_rfin, 0);
        exp_q = '{0};
        check_log("t6", exp_q);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
